// File: rtl/victim_wb_buffer_pkg.sv
// Shared encodings and address-field layout for the victim write-back buffer.
package victim_wb_buffer_pkg;

  // Address layout shared with cache4way: {tag, index, word offset, byte offset}
  localparam int unsigned BYTE_OFFSET_W = 2;
  localparam int unsigned WORD_OFFSET_W = 2;
  localparam int unsigned LINE_OFFSET_W = WORD_OFFSET_W + BYTE_OFFSET_W;
  localparam int unsigned INDEX_W       = 6;
  localparam int unsigned TAG_LSB       = LINE_OFFSET_W + INDEX_W;

  typedef logic [1:0] ent_state_t;
  typedef logic [1:0] drain_state_t;

  // Line entry states
  localparam ent_state_t ENT_FREE = 2'd0;
  localparam ent_state_t ENT_FILL = 2'd1;
  localparam ent_state_t ENT_FULL = 2'd2;

  // Drain FSM states
  localparam drain_state_t DRAIN_IDLE    = 2'd0;
  localparam drain_state_t DRAIN_WRITE   = 2'd1;
  localparam drain_state_t DRAIN_RELEASE = 2'd2;

endpackage

// File: rtl/victim_wb_buffer_line_entry.sv
// One write-back line entry: word storage, arrival mask, state and address compare.
module wb_line_entry
  import victim_wb_buffer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH        = 32,
  parameter int unsigned WORD_NUM          = 4,
  parameter int unsigned WORD_OFFSET_WIDTH = 2,
  parameter int unsigned LINE_ADR_WIDTH    = 28
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc,
  input  logic [LINE_ADR_WIDTH-1:0]    alloc_adr,
  input  logic                         wr_en,
  input  logic [WORD_OFFSET_WIDTH-1:0] wr_word,
  input  logic [WORD_WIDTH-1:0]        wr_dat,
  input  logic                         free,
  input  logic [WORD_OFFSET_WIDTH-1:0] rd_word,
  output logic [WORD_WIDTH-1:0]        rd_dat,
  output ent_state_t                   state,
  output logic [LINE_ADR_WIDTH-1:0]    line_adr,
  input  logic [LINE_ADR_WIDTH-1:0]    lkp_line,
  output logic                         lkp_hit,
  output logic                         fill_done
);

  logic [WORD_WIDTH-1:0] data [WORD_NUM];
  logic [WORD_NUM-1:0]   mask;
  logic [WORD_NUM-1:0]   mask_next;
  logic [WORD_NUM-1:0]   word_bit;
  logic                  filling;

  assign word_bit = WORD_NUM'(1) << wr_word;
  assign filling  = alloc || (state == ENT_FILL);

  // Arrival mask after this cycle's word; a same-cycle alloc starts from empty
  always_comb begin
    mask_next = mask;
    if (alloc) begin
      mask_next = wr_en ? word_bit : '0;
    end else if ((state == ENT_FILL) && wr_en) begin
      mask_next = mask | word_bit;
    end
  end

  assign fill_done = filling && (&mask_next);

  // Entry lifecycle FREE -> FILL -> FULL -> FREE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ENT_FREE;
      mask     <= '0;
      line_adr <= '0;
    end else if (alloc) begin
      state    <= (&mask_next) ? ENT_FULL : ENT_FILL;
      mask     <= mask_next;
      line_adr <= alloc_adr;
    end else if (free) begin
      state <= ENT_FREE;
    end else if (state == ENT_FILL) begin
      mask <= mask_next;
      if (&mask_next) begin
        state <= ENT_FULL;
      end
    end
  end

  // Word storage; a repeated index simply overwrites
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WORD_NUM; i++) begin
        data[i] <= '0;
      end
    end else if (filling && wr_en) begin
      data[wr_word] <= wr_dat;
    end
  end

  assign rd_dat  = data[rd_word];
  assign lkp_hit = (state != ENT_FREE) && (lkp_line == line_adr);

endmodule

// File: rtl/victim_wb_buffer.sv
// Victim write-back buffer: collects dirty victim lines and drains them word by word.
module victim_wb_buffer
  import victim_wb_buffer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH        = 32,
  parameter int unsigned ADR_WIDTH         = 32,
  parameter int unsigned WORD_NUM          = 4,
  parameter int unsigned WORD_OFFSET_WIDTH = WORD_OFFSET_W,
  parameter int unsigned BYTE_OFFSET_WIDTH = BYTE_OFFSET_W,
  parameter int unsigned DEPTH             = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vic_start_i,
  input  logic                         vic_dirty_i,
  input  logic [ADR_WIDTH-1:0]         vic_adr_i,
  input  logic                         vic_valid_i,
  input  logic [WORD_OFFSET_WIDTH-1:0] vic_word_i,
  input  logic [WORD_WIDTH-1:0]        vic_dat_i,
  output logic                         vic_ready_o,
  output logic                         mem_wr_req_o,
  output logic [ADR_WIDTH-1:0]         mem_wr_adr_o,
  output logic [WORD_WIDTH-1:0]        mem_wr_dat_o,
  input  logic                         mem_wr_ack_i,
  input  logic [ADR_WIDTH-1:0]         lkp_adr_i,
  output logic                         lkp_hit_o,
  output logic                         empty_o,
  output logic                         err_o
);

  localparam int unsigned LINE_LSB       = WORD_OFFSET_WIDTH + BYTE_OFFSET_WIDTH;
  localparam int unsigned LINE_ADR_WIDTH = ADR_WIDTH - LINE_LSB;
  localparam int unsigned PTR_W          = $clog2(DEPTH);
  localparam int unsigned CNT_W          = PTR_W + 1;

  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [CNT_W-1:0]             count;
  drain_state_t                 drain_state;
  logic [WORD_OFFSET_WIDTH-1:0] cnt;

  ent_state_t                   ent_state   [DEPTH];
  logic [LINE_ADR_WIDTH-1:0]    ent_line    [DEPTH];
  logic [WORD_WIDTH-1:0]        ent_rd_dat  [DEPTH];
  logic [DEPTH-1:0]             ent_hit;
  logic [DEPTH-1:0]             ent_fill_done;
  logic [DEPTH-1:0]             ent_busy;

  logic fill_active;
  logic alloc_ok;
  logic clean_start;
  logic drop_words;
  logic release_head;
  logic unused_adr_bits;

  assign fill_active  = (ent_state[tail] == ENT_FILL);
  assign vic_ready_o  = (count != CNT_W'(DEPTH)) && !fill_active;
  assign alloc_ok     = vic_start_i && vic_dirty_i && vic_ready_o;
  assign clean_start  = vic_start_i && !vic_dirty_i && vic_ready_o;
  assign release_head = (drain_state == DRAIN_RELEASE);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    wb_line_entry #(
      .WORD_WIDTH        (WORD_WIDTH),
      .WORD_NUM          (WORD_NUM),
      .WORD_OFFSET_WIDTH (WORD_OFFSET_WIDTH),
      .LINE_ADR_WIDTH    (LINE_ADR_WIDTH)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc     (alloc_ok && (tail == PTR_W'(i))),
      .alloc_adr (vic_adr_i[ADR_WIDTH-1:LINE_LSB]),
      .wr_en     (vic_valid_i && (tail == PTR_W'(i)) && (alloc_ok || fill_active)),
      .wr_word   (vic_word_i),
      .wr_dat    (vic_dat_i),
      .free      (release_head && (head == PTR_W'(i))),
      .rd_word   (cnt),
      .rd_dat    (ent_rd_dat[i]),
      .state     (ent_state[i]),
      .line_adr  (ent_line[i]),
      .lkp_line  (lkp_adr_i[ADR_WIDTH-1:LINE_LSB]),
      .lkp_hit   (ent_hit[i]),
      .fill_done (ent_fill_done[i])
    );
    assign ent_busy[i] = (ent_state[i] != ENT_FREE);
  end

  // Fill pointer and allocated-entry count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail  <= '0;
      count <= '0;
    end else begin
      if (ent_fill_done[tail]) begin
        tail <= tail + PTR_W'(1);
      end
      case ({alloc_ok, release_head})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky protocol error; words after a clean start are silently discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o      <= 1'b0;
      drop_words <= 1'b0;
    end else begin
      if (vic_start_i) begin
        drop_words <= clean_start;
      end
      if ((vic_start_i && !vic_ready_o) ||
          (vic_valid_i && !fill_active && !alloc_ok && !clean_start && !drop_words)) begin
        err_o <= 1'b1;
      end
    end
  end

  // Drain FSM: write the head line in word order, then free it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_state <= DRAIN_IDLE;
      cnt         <= '0;
      head        <= '0;
    end else begin
      case (drain_state)
        DRAIN_IDLE: begin
          if (ent_state[head] == ENT_FULL) begin
            drain_state <= DRAIN_WRITE;
            cnt         <= '0;
          end
        end
        DRAIN_WRITE: begin
          if (mem_wr_ack_i) begin
            if (cnt == WORD_OFFSET_WIDTH'(WORD_NUM - 1)) begin
              drain_state <= DRAIN_RELEASE;
            end else begin
              cnt <= cnt + WORD_OFFSET_WIDTH'(1);
            end
          end
        end
        DRAIN_RELEASE: begin
          head        <= head + PTR_W'(1);
          drain_state <= DRAIN_IDLE;
        end
        default: drain_state <= DRAIN_IDLE;
      endcase
    end
  end

  assign mem_wr_req_o = (drain_state == DRAIN_WRITE);
  assign mem_wr_adr_o = mem_wr_req_o ? {ent_line[head], cnt, {BYTE_OFFSET_WIDTH{1'b0}}} : '0;
  assign mem_wr_dat_o = mem_wr_req_o ? ent_rd_dat[head] : '0;

  assign lkp_hit_o = |ent_hit;
  assign empty_o   = ~|ent_busy;

  assign unused_adr_bits = ^{vic_adr_i[LINE_LSB-1:0], lkp_adr_i[LINE_LSB-1:0]};

endmodule

// File: tb/tb_victim_wb_buffer.sv
// Scoreboard bench for victim_wb_buffer: directed scenarios plus randomized lines.
module tb_victim_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vic_start_i, vic_dirty_i, vic_valid_i;
  logic [31:0] vic_adr_i, vic_dat_i;
  logic [1:0]  vic_word_i;
  logic        vic_ready_o, mem_wr_req_o, mem_wr_ack_i;
  logic [31:0] mem_wr_adr_o, mem_wr_dat_o, lkp_adr_i;
  logic        lkp_hit_o, empty_o, err_o;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_stall = 0;
  bit          ack_rand = 1'b0;
  bit          ack_hold = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] p_adr, p_dat;
  wr_t         mon_e;
  int          waitc = 0;
  int          cur_stall = 0;

  always #5 clk = ~clk;

  victim_wb_buffer #(.WORD_WIDTH(32), .ADR_WIDTH(32), .WORD_NUM(4), .DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vic_start_i  (vic_start_i),
    .vic_dirty_i  (vic_dirty_i),
    .vic_adr_i    (vic_adr_i),
    .vic_valid_i  (vic_valid_i),
    .vic_word_i   (vic_word_i),
    .vic_dat_i    (vic_dat_i),
    .vic_ready_o  (vic_ready_o),
    .mem_wr_req_o (mem_wr_req_o),
    .mem_wr_adr_o (mem_wr_adr_o),
    .mem_wr_dat_o (mem_wr_dat_o),
    .mem_wr_ack_i (mem_wr_ack_i),
    .lkp_adr_i    (lkp_adr_i),
    .lkp_hit_o    (lkp_hit_o),
    .empty_o      (empty_o),
    .err_o        (err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory side: one-cycle ack pulses after a programmable or random stall
  initial begin
    mem_wr_ack_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || mem_wr_ack_i) begin
        mem_wr_ack_i = 1'b0;
        waitc = 0;
      end else if (mem_wr_req_o && !ack_hold) begin
        if (waitc == 0) cur_stall = ack_rand ? int'($urandom_range(0, 4)) : ack_stall;
        if (waitc >= cur_stall) mem_wr_ack_i = 1'b1;
        else waitc++;
      end
    end
  end

  // Monitor: every accepted write is popped from the scoreboard; pending requests must hold
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("req_hold", {31'd0, mem_wr_req_o}, 32'd1);
          check("adr_hold", mem_wr_adr_o, p_adr);
          check("dat_hold", mem_wr_dat_o, p_dat);
        end
        if (mem_wr_req_o && mem_wr_ack_i) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_write: got adr 0x%08h dat 0x%08h expected no write",
                     mem_wr_adr_o, mem_wr_dat_o);
          end else begin
            mon_e = sb.pop_front();
            check("wr_adr", mem_wr_adr_o, mon_e.adr);
            check("wr_dat", mem_wr_dat_o, mon_e.dat);
          end
        end
        pend  = mem_wr_req_o && !mem_wr_ack_i;
        p_adr = mem_wr_adr_o;
        p_dat = mem_wr_dat_o;
      end
    end
  end

  // Drive one victim line; ord packs arrival order, d packs data indexed by word
  task automatic send_line(input logic [31:0] adr, input bit dirty, input bit same_cycle,
                           input int max_gap, input bit dup, input logic [7:0] ord,
                           input logic [127:0] d);
    int k;
    int g;
    logic [1:0] w;
    @(posedge clk); #1;
    vic_start_i = 1'b1;
    vic_dirty_i = dirty;
    vic_adr_i   = adr;
    k = 0;
    if (same_cycle) begin
      w = ord[1:0];
      vic_valid_i = 1'b1;
      vic_word_i  = w;
      vic_dat_i   = d[32*int'(w) +: 32];
      k = 1;
    end
    @(posedge clk); #1;
    vic_start_i = 1'b0;
    vic_valid_i = 1'b0;
    while (k < 4) begin
      g = int'($urandom_range(0, max_gap));
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      w = ord[2*k +: 2];
      if (dup && k < 3) begin
        vic_valid_i = 1'b1;
        vic_word_i  = w;
        vic_dat_i   = $urandom;
        @(posedge clk); #1;
      end
      vic_valid_i = 1'b1;
      vic_word_i  = w;
      vic_dat_i   = d[32*int'(w) +: 32];
      @(posedge clk); #1;
      vic_valid_i = 1'b0;
      k++;
    end
    if (dirty) begin
      for (int i = 0; i < 4; i++) begin
        sb.push_back('{{adr[31:4], 2'(i), 2'b00}, d[32*i +: 32]});
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!vic_ready_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!vic_ready_o) check("ready_timeout", {31'd0, vic_ready_o}, 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || !empty_o) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, empty_o}, 32'd1);
    check({name, "_sb"}, sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("err_after_reset", {31'd0, err_o}, 32'd0);
  endtask

  function automatic logic [7:0] rand_order();
    logic [1:0] o [4];
    logic [1:0] t;
    int j;
    for (int i = 0; i < 4; i++) o[i] = 2'(i);
    for (int i = 3; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = o[i]; o[i] = o[j]; o[j] = t;
    end
    return {o[3], o[2], o[1], o[0]};
  endfunction

  function automatic logic [127:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int n;
    int t;
    rst_n = 1'b0;
    vic_start_i = 1'b0; vic_dirty_i = 1'b0; vic_valid_i = 1'b0;
    vic_adr_i = '0; vic_word_i = '0; vic_dat_i = '0; lkp_adr_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, vic_ready_o}, 32'd1);
    check("rst_req",   {31'd0, mem_wr_req_o}, 32'd0);
    check("rst_adr",   mem_wr_adr_o, 32'd0);
    check("rst_dat",   mem_wr_dat_o, 32'd0);
    check("rst_hit",   {31'd0, lkp_hit_o}, 32'd0);
    check("rst_empty", {31'd0, empty_o}, 32'd1);
    check("rst_err",   {31'd0, err_o}, 32'd0);

    // Line 0x1230, words arriving 2,3,0,1, drained 0..3
    lkp_adr_i = 32'h1238;
    ack_hold  = 1'b1;
    fork
      send_line(32'h1230, 1'b1, 1'b0, 0, 1'b0, {2'd1, 2'd0, 2'd3, 2'd2},
                {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      begin
        @(posedge clk);
        repeat (2) @(negedge clk);
        check("hit_fill", {31'd0, lkp_hit_o}, 32'd1);
      end
    join
    repeat (2) @(negedge clk);
    check("hit_full", {31'd0, lkp_hit_o}, 32'd1);
    check("first_req", {31'd0, mem_wr_req_o}, 32'd1);
    check("first_adr", mem_wr_adr_o, 32'h1230);
    check("first_dat", mem_wr_dat_o, 32'hA0);
    lkp_adr_i = 32'h1240;
    #1 check("hit_other_line", {31'd0, lkp_hit_o}, 32'd0);
    lkp_adr_i = 32'h1238;
    ack_hold = 1'b0;
    wait_drain("drain_1230");
    check("hit_after_drain", {31'd0, lkp_hit_o}, 32'd0);

    // Clean victim line: nothing buffered, no error
    send_line(32'h40, 1'b0, 1'b0, 0, 1'b0, {2'd3, 2'd2, 2'd1, 2'd0}, rand_data());
    repeat (4) begin
      @(negedge clk);
      check("clean_no_req", {31'd0, mem_wr_req_o}, 32'd0);
    end
    check("clean_err", {31'd0, err_o}, 32'd0);
    check("clean_empty", {31'd0, empty_o}, 32'd1);

    // Two full lines with memory stalled, then an overflowing start
    ack_hold = 1'b1;
    send_line(32'h2000, 1'b1, 1'b0, 1, 1'b0, rand_order(), rand_data());
    wait_ready();
    send_line(32'h3000, 1'b1, 1'b1, 1, 1'b0, rand_order(), rand_data());
    @(negedge clk);
    check("ready_full", {31'd0, vic_ready_o}, 32'd0);
    @(posedge clk); #1;
    vic_start_i = 1'b1; vic_dirty_i = 1'b1; vic_adr_i = 32'h4000;
    @(posedge clk); #1;
    vic_start_i = 1'b0;
    @(negedge clk);
    check("err_overflow", {31'd0, err_o}, 32'd1);
    lkp_adr_i = 32'h2008;
    ack_hold = 1'b0;
    n = 0; t = 0;
    while (n < 4 && t < 200) begin
      @(negedge clk);
      t++;
      if (mem_wr_req_o && mem_wr_ack_i) n++;
    end
    check("line1_handshakes", n, 32'd4);
    @(negedge clk);
    check("ready_in_release", {31'd0, vic_ready_o}, 32'd0);
    check("hit_in_release", {31'd0, lkp_hit_o}, 32'd1);
    @(negedge clk);
    check("ready_after_release", {31'd0, vic_ready_o}, 32'd1);
    check("hit_after_release", {31'd0, lkp_hit_o}, 32'd0);
    wait_drain("drain_two");
    do_reset();

    // Five-cycle ack stall with the next line filling concurrently
    ack_stall = 5;
    send_line(32'h5000, 1'b1, 1'b1, 1, 1'b0, rand_order(), rand_data());
    wait_ready();
    send_line(32'h6000, 1'b1, 1'b0, 1, 1'b1, rand_order(), rand_data());
    @(negedge clk);
    check("concurrent_drain_req", {31'd0, mem_wr_req_o}, 32'd1);
    check("concurrent_full_ready", {31'd0, vic_ready_o}, 32'd0);
    wait_drain("drain_stall");

    // Reset in the middle of a line drain
    ack_stall = 3;
    send_line(32'h7000, 1'b1, 1'b0, 0, 1'b0, rand_order(), rand_data());
    n = 0; t = 0;
    while (n < 1 && t < 200) begin
      @(negedge clk);
      t++;
      if (mem_wr_req_o && mem_wr_ack_i) n++;
    end
    check("mid_handshake", n, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req",   {31'd0, mem_wr_req_o}, 32'd0);
    check("mid_rst_adr",   mem_wr_adr_o, 32'd0);
    check("mid_rst_dat",   mem_wr_dat_o, 32'd0);
    check("mid_rst_empty", {31'd0, empty_o}, 32'd1);
    check("mid_rst_err",   {31'd0, err_o}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized lines against the scoreboard
    ack_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      wait_ready();
      send_line($urandom, ($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1, 2,
                $urandom_range(0, 3) == 0, rand_order(), rand_data());
    end
    wait_drain("drain_random");
    check("random_err", {31'd0, err_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
